alu: RTL and testbench

- Registered 32-bit integer ALU for the CPU datapath execute stage.
- Takes operands A/B and a 4-bit operation code, and produces result C plus a packed flags byte (CF, OF, ZF, SF).
- Outputs are registered with one-cycle latency. A valid strobe travels alongside the data.

---
 rtl/alu.sv | 174 +++++++++++++++++
 tb/tb_alu.sv | 97 +++++++++
 2 files changed

// File: rtl/alu.sv
// Registered integer ALU for the execute stage: one-cycle latency, with a valid strobe alongside the data.
// Optional macro ALU_SLTU_EN turns opcode 12 into SLTU; when it is undefined, opcode 12 acts as NOP.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Mod,
    output logic [WIDTH-1:0] C,
    output logic [7:0]       flags,
    output logic             out_valid
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADDU = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SUBU = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;
`ifdef ALU_SLTU_EN
    localparam logic [3:0] OP_SLTU = 4'd12;
`endif

    logic [WIDTH-1:0] c_q, c_d;
    logic [7:0]       flags_q, flags_d;
    logic             valid_q, valid_d;

    // Arithmetic is done one bit wider so that carry/borrow falls out of the top bit.
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt_bit;
    logic [SHW-1:0]   shamt;

    assign sum_ext  = {1'b0, A} + {1'b0, B};
    assign diff_ext = {1'b0, A} - {1'b0, B};
    assign add_ovf  = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ext[WIDTH-1] != A[WIDTH-1]);
    assign slt_bit  = $signed(A) < $signed(B);
    assign shamt    = B[SHW-1:0];

    // Logarithmic barrel shifters; stage gi shifts by 2**gi when shamt[gi] is set.
    logic [WIDTH-1:0] sll_stage [0:SHW];
    logic [WIDTH-1:0] srl_stage [0:SHW];
    logic [WIDTH-1:0] sra_stage [0:SHW];

    assign sll_stage[0] = A;
    assign srl_stage[0] = A;
    assign sra_stage[0] = A;

    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_shift
            localparam int SH = 1 << gi;
            assign sll_stage[gi+1] = shamt[gi] ? {sll_stage[gi][WIDTH-1-SH:0], {SH{1'b0}}}
                                               : sll_stage[gi];
            assign srl_stage[gi+1] = shamt[gi] ? {{SH{1'b0}}, srl_stage[gi][WIDTH-1:SH]}
                                               : srl_stage[gi];
            assign sra_stage[gi+1] = shamt[gi] ? {{SH{A[WIDTH-1]}}, sra_stage[gi][WIDTH-1:SH]}
                                               : sra_stage[gi];
        end
    endgenerate

    logic [WIDTH-1:0] res;
    logic             cf, of, sf, zf_en, zf;

    always_comb begin
        res   = '0;
        cf    = 1'b0;
        of    = 1'b0;
        sf    = 1'b0;
        zf_en = 1'b1;
        case (Mod)
            OP_ADD: begin
                res = sum_ext[WIDTH-1:0];
                cf  = sum_ext[WIDTH];
                of  = add_ovf;
                sf  = res[WIDTH-1];
            end
            OP_ADDU: begin
                res = sum_ext[WIDTH-1:0];
                cf  = sum_ext[WIDTH];
            end
            OP_SUB: begin
                res = diff_ext[WIDTH-1:0];
                cf  = diff_ext[WIDTH];
                of  = sub_ovf;
                sf  = res[WIDTH-1];
            end
            OP_SUBU: begin
                res = diff_ext[WIDTH-1:0];
                cf  = diff_ext[WIDTH];
            end
            OP_SLT: begin
                res = {{(WIDTH-1){1'b0}}, slt_bit};
            end
            OP_AND: begin
                res = A & B;
                sf  = res[WIDTH-1];
            end
            OP_OR: begin
                res = A | B;
                sf  = res[WIDTH-1];
            end
            OP_XOR: begin
                res = A ^ B;
                sf  = res[WIDTH-1];
            end
            OP_SLL: begin
                res = sll_stage[SHW];
                of  = (shamt == SHW'(1)) && (A[WIDTH-1] != A[WIDTH-2]);
                sf  = res[WIDTH-1];
            end
            OP_SRL: begin
                res = srl_stage[SHW];
                sf  = res[WIDTH-1];
            end
            OP_SRA: begin
                res = sra_stage[SHW];
                sf  = res[WIDTH-1];
            end
`ifdef ALU_SLTU_EN
            OP_SLTU: begin
                res = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
                cf  = diff_ext[WIDTH];
            end
`endif
            default: begin
                // NOP and unassigned opcodes: zero result and no flags, ZF included.
                zf_en = 1'b0;
            end
        endcase
        zf = zf_en && (res == '0);
    end

    always_comb begin
        c_d     = c_q;
        flags_d = flags_q;
        valid_d = 1'b0;
        if (in_valid) begin
            c_d     = res;
            flags_d = {4'b0000, cf, of, zf, sf};
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q     <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            c_q     <= c_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign C         = c_q;
    assign flags     = flags_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: each step queues its expected outputs, and they are
// popped and compared one cycle later.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] A, B;
    logic [3:0]  Mod;
    logic [31:0] C;
    logic [7:0]  flags;
    logic        out_valid;

    alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .Mod(Mod),
        .C(C), .flags(flags), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] c;
        logic [7:0]  f;
        logic        v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic compare_out();
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        assert (C === e.c) passed++;
        else $error("FAIL %s C: got %h expected %h", e.tag, C, e.c);
        checks++;
        assert (flags === e.f) passed++;
        else $error("FAIL %s flags: got %h expected %h", e.tag, flags, e.f);
        checks++;
        assert (out_valid === e.v) passed++;
        else $error("FAIL %s out_valid: got %b expected %b", e.tag, out_valid, e.v);
        $display("txn %-10s C=%h flags=%h out_valid=%b", e.tag, C, flags, out_valid);
    endtask

    // Drive one cycle of stimulus, queue its expectation, then check it after the edge.
    task automatic step(input string tag, input logic r, input logic v, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ec, input logic [7:0] ef, input logic ev);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = v; Mod = op; A = a; B = b;
        e.tag = tag; e.c = ec; e.f = ef; e.v = ev;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; Mod = 4'd0; A = '0; B = '0;
        // flags byte = {4'b0, CF, OF, ZF, SF}
        step("rst0",     1, 1, 4'd1,  32'h1,        32'h2,        32'h0,        8'h00, 0);
        step("rst1",     1, 1, 4'd1,  32'h1,        32'h2,        32'h0,        8'h00, 0);
        step("add12",    0, 1, 4'd1,  32'h1,        32'h2,        32'h3,        8'h00, 1);
        step("add_ovf",  0, 1, 4'd1,  32'h7fffffff, 32'h1,        32'h80000000, 8'h05, 1);
        step("addu_cy",  0, 1, 4'd2,  32'hffffffff, 32'h1,        32'h0,        8'h0A, 1);
        step("sub35",    0, 1, 4'd3,  32'h3,        32'h5,        32'hfffffffe, 8'h09, 1);
        step("sub_ovf",  0, 1, 4'd3,  32'h80000000, 32'h1,        32'h7fffffff, 8'h04, 1);
        step("subu12",   0, 1, 4'd4,  32'h1,        32'h2,        32'hffffffff, 8'h08, 1);
        step("slt_t",    0, 1, 4'd5,  32'hffffffff, 32'h1,        32'h1,        8'h00, 1);
        step("slt_f",    0, 1, 4'd5,  32'h5,        32'h2,        32'h0,        8'h02, 1);
        step("and",      0, 1, 4'd6,  32'hff00ff00, 32'h0f0f0f0f, 32'h0f000f00, 8'h00, 1);
        step("or",       0, 1, 4'd7,  32'h80000000, 32'h1,        32'h80000001, 8'h01, 1);
        step("xor_z",    0, 1, 4'd8,  32'h12345678, 32'h12345678, 32'h0,        8'h02, 1);
        step("sll_ovf",  0, 1, 4'd9,  32'h40000000, 32'h1,        32'h80000000, 8'h05, 1);
        step("sll31",    0, 1, 4'd9,  32'h1,        32'd31,       32'h80000000, 8'h01, 1);
        step("sra4",     0, 1, 4'd11, 32'hf0000000, 32'h4,        32'hff000000, 8'h01, 1);
        step("srl_hiB",  0, 1, 4'd10, 32'h80000000, 32'hffffffe1, 32'h40000000, 8'h00, 1);
        step("srl0",     0, 1, 4'd10, 32'h12345678, 32'h0,        32'h12345678, 8'h00, 1);
        step("hold",     0, 0, 4'd1,  32'h1,        32'h1,        32'h12345678, 8'h00, 0);
        step("sub_hold", 0, 1, 4'd3,  32'h3,        32'h5,        32'hfffffffe, 8'h09, 1);
        step("hold2",    0, 0, 4'd8,  32'h0,        32'h0,        32'hfffffffe, 8'h09, 0);
        step("nop",      0, 1, 4'd0,  32'h12345678, 32'h87654321, 32'h0,        8'h00, 1);
`ifdef ALU_SLTU_EN
        step("op12",     0, 1, 4'd12, 32'h1,        32'hffffffff, 32'h1,        8'h08, 1);
`else
        step("op12",     0, 1, 4'd12, 32'h1,        32'hffffffff, 32'h0,        8'h00, 1);
`endif
        step("op15",     0, 1, 4'd15, 32'h5,        32'h5,        32'h0,        8'h00, 1);
        step("rst_mid",  1, 1, 4'd1,  32'h5,        32'h5,        32'h0,        8'h00, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
